// File: rtl/button_conditioner.sv
// button_conditioner: sync, debounce and arbitrate raw gamepad buttons into one-cycle press pulses.
// Define BTN_AUTOREPEAT_EN to build per-direction auto-repeat.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_up,
  input  logic raw_down,
  input  logic raw_left,
  input  logic raw_right,
  input  logic raw_A,
  input  logic raw_B,
  input  logic raw_start,
  output logic btn_up,
  output logic btn_down,
  output logic btn_left,
  output logic btn_right,
  output logic btn_A,
  output logic btn_B,
  output logic btn_start
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_params
    $error("button_conditioner: parameter out of range");
  end
  // Bit order: 0 up, 1 down, 2 left, 3 right, 4 A, 5 B, 6 start
  logic [6:0] raw, s1_q, s2_q, stable_q, stable_d, prev_q, press, ev, btn_d, btn_q;
  logic [3:0] rep;
  logic [CW-1:0] cnt_q [7];
  logic [CW-1:0] cnt_d [7];
  assign raw = {raw_start, raw_B, raw_A, raw_right, raw_left, raw_down, raw_up};
  always_comb begin
    for (int i = 0; i < 7; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i] = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) stable_d[i] = s2_q[i];
        else cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end
  assign press = stable_q & ~prev_q;
`ifdef BTN_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);
  logic [RW-1:0] rcnt_q [4];
  logic [RW-1:0] rcnt_d [4];
  // Down-counter reloads on every repeat, so a dropped repeat keeps its schedule
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rep[i] = stable_q[i] & ~press[i] & (rcnt_q[i] == '0);
      rcnt_d[i] = press[i] ? RW'(REPEAT_DELAY - 1) :
                  rep[i] ? RW'(REPEAT_PERIOD - 1) :
                  stable_q[i] ? rcnt_q[i] - 1'b1 : rcnt_q[i];
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) for (int i = 0; i < 4; i++) rcnt_q[i] <= '0;
    else rcnt_q <= rcnt_d;
  end
`else
  assign rep = '0;
`endif
  assign ev = press | {3'b000, rep};
  assign btn_d = {ev[6], ev[5] & ~ev[4], ev[4], ev[3] & ~|ev[2:0], ev[2] & ~|ev[1:0],
                  ev[1] & ~ev[0], ev[0]};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
      stable_q <= '0;
      prev_q <= '0;
      btn_q <= '0;
      for (int i = 0; i < 7; i++) cnt_q[i] <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      stable_q <= stable_d;
      prev_q <= stable_q;
      btn_q <= btn_d;
      cnt_q <= cnt_d;
    end
  end
  assign {btn_start, btn_B, btn_A, btn_right, btn_left, btn_down, btn_up} = btn_q;
endmodule
